// File: rtl/uop_issue_queue.sv
// Circular FIFO between the decoder and execute: takes 1-3 uop bundles and issues one uop per cycle.
// A bundle written on one edge is visible the following cycle; the decoder is held off while fewer than 3 slots are free.
module uop_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [15:0]      uop_0,
  input  logic [15:0]      uop_1,
  input  logic [15:0]      uop_2,
  input  logic [1:0]       uop_count,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [15:0]      ex_uop,
  output logic             ex_last,
  output logic             sf_written,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [16:0]      mem [DEPTH];
  logic [1:0]       n;
  logic [PTR_W:0]   free_cnt;
  logic [PTR_W:0]   n_ext;
  logic [PTR_W:0]   occ_next;
  logic             accept;
  logic             pop;

  // uop_count 11 is treated the same as 10: three uops.
  always_comb begin
    n = 2'd3;
    if (uop_count == 2'd0)      n = 2'd1;
    else if (uop_count == 2'd1) n = 2'd2;
  end

  assign free_cnt = DEPTH_V - occupancy;
  assign feed_req = (free_cnt >= (PTR_W+1)'(3)) & ~flush;
  assign accept   = feed_req & feed_ack;
  assign ex_valid = (occupancy != '0) & ~flush;
  assign pop      = ex_valid & ex_ready;
  assign ex_uop   = mem[rd_ptr][15:0];
  assign ex_last  = mem[rd_ptr][16];
  assign n_ext    = accept ? (PTR_W+1)'(n) : '0;
  assign occ_next = occupancy + n_ext - (PTR_W+1)'(pop);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      sf_written <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      occupancy  <= '0;
      sf_written <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(n);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy  <= occ_next;
      sf_written <= pop & ex_uop[8];
    end
  end

  // Oldest uop of the instruction goes first; only the final uop (uop_0) carries last.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (n)
        2'd1: mem[wr_ptr] <= {1'b1, uop_0};
        2'd2: begin
          mem[wr_ptr]              <= {1'b0, uop_1};
          mem[wr_ptr + PTR_W'(1)]  <= {1'b1, uop_0};
        end
        default: begin
          mem[wr_ptr]              <= {1'b0, uop_2};
          mem[wr_ptr + PTR_W'(1)]  <= {1'b0, uop_1};
          mem[wr_ptr + PTR_W'(2)]  <= {1'b1, uop_0};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Bench for uop_issue_queue: queue-based reference model plus directed and random bundle traffic.
module tb_uop_issue_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             a_rst;
  logic             flush;
  logic             feed_req;
  logic             feed_ack;
  logic [15:0]      uop_0, uop_1, uop_2;
  logic [1:0]       uop_count;
  logic             ex_valid;
  logic             ex_ready;
  logic [15:0]      ex_uop;
  logic             ex_last;
  logic             sf_written;
  logic [PTR_W:0]   occupancy;

  int checks = 0;
  int errors = 0;

  logic [16:0] q[$];
  logic        exp_sf = 1'b0;

  uop_issue_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush), .feed_req(feed_req), .feed_ack(feed_ack),
    .uop_0(uop_0), .uop_1(uop_1), .uop_2(uop_2), .uop_count(uop_count),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_uop(ex_uop), .ex_last(ex_last),
    .sf_written(sf_written), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor and reference model: check outputs mid-cycle, then apply the coming edge to the model.
  always @(negedge clk) begin
    if (!a_rst) begin
      q.delete();
      exp_sf = 1'b0;
    end else begin
      int sz;
      logic nxt_sf;
      logic [16:0] it;
      int nb;
      sz = q.size();
      check("ex_valid", 32'(ex_valid), 32'((sz != 0) && !flush));
      check("occupancy", 32'(occupancy), 32'(sz));
      check("feed_req", 32'(feed_req), 32'(((DEPTH - sz) >= 3) && !flush));
      check("sf_written", 32'(sf_written), 32'(exp_sf));
      if (sz != 0) begin
        check("ex_uop", 32'(ex_uop), 32'(q[0][15:0]));
        check("ex_last", 32'(ex_last), 32'(q[0][16]));
      end
      nxt_sf = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (sz != 0 && ex_ready) begin
          it = q.pop_front();
          nxt_sf = it[8];
        end
        if (feed_ack && (DEPTH - sz) >= 3) begin
          nb = (uop_count == 2'd0) ? 1 : (uop_count == 2'd1) ? 2 : 3;
          if (nb == 3) q.push_back({1'b0, uop_2});
          if (nb >= 2) q.push_back({1'b0, uop_1});
          q.push_back({1'b1, uop_0});
        end
      end
      exp_sf = nxt_sf;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [1:0] cnt, input logic [15:0] u0, input logic [15:0] u1,
                        input logic [15:0] u2);
    feed_ack = 1'b1; uop_count = cnt; uop_0 = u0; uop_1 = u1; uop_2 = u2;
    cyc();
    feed_ack = 1'b0;
  endtask

  initial begin
    int wait_cnt;
    a_rst = 1'b0; flush = 1'b0; feed_ack = 1'b0; ex_ready = 1'b0;
    uop_0 = '0; uop_1 = '0; uop_2 = '0; uop_count = '0;
    #12;
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_feed_req", 32'(feed_req), 32'd1);
    check("rst_sf_written", 32'(sf_written), 32'd0);
    @(posedge clk); #1;
    a_rst = 1'b1;
    cyc();

    // Single 3-uop instruction, execute always ready.
    ex_ready = 1'b1;
    bundle(2'b10, 16'h0100, 16'h1111, 16'h2222);
    repeat (6) cyc();

    // Backpressure: third bundle must be refused at occupancy 6.
    ex_ready = 1'b0;
    repeat (3) bundle(2'b10, 16'($urandom), 16'($urandom), 16'($urandom));
    check("bp_occupancy6", 32'(occupancy), 32'd6);
    check("bp_feed_req0", 32'(feed_req), 32'd0);
    ex_ready = 1'b1;
    cyc();
    ex_ready = 1'b0;
    check("bp_occupancy5", 32'(occupancy), 32'd5);
    check("bp_feed_req1", 32'(feed_req), 32'd1);
    ex_ready = 1'b1;
    repeat (8) cyc();

    // Accept and pop on the same edge from occupancy 4.
    ex_ready = 1'b0;
    bundle(2'b10, 16'h0a00, 16'h0a01, 16'h0a02);
    bundle(2'b00, 16'h0b00, 16'h0, 16'h0);
    check("simul_occ4", 32'(occupancy), 32'd4);
    ex_ready = 1'b1;
    bundle(2'b01, 16'h0c00, 16'h0c01, 16'h0);
    check("simul_occ5", 32'(occupancy), 32'd5);
    repeat (8) cyc();

    // Flush at occupancy 5 with a bundle offered in the same cycle.
    ex_ready = 1'b0;
    bundle(2'b11, 16'h0100, 16'h0101, 16'h0102);
    bundle(2'b01, 16'h0103, 16'h0104, 16'h0);
    check("flush_occ5", 32'(occupancy), 32'd5);
    flush = 1'b1;
    bundle(2'b10, 16'h0fff, 16'h0ffe, 16'h0ffd);
    flush = 1'b0;
    check("flush_occ0", 32'(occupancy), 32'd0);
    check("flush_ex_valid0", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1;
    repeat (4) cyc();

    // Random traffic: many bundles of mixed sizes, pointers wrap repeatedly.
    for (int i = 0; i < 300; i++) begin
      feed_ack  = ($urandom_range(0, 9) < 7);
      uop_count = 2'($urandom_range(0, 3));
      uop_0 = 16'($urandom); uop_1 = 16'($urandom); uop_2 = 16'($urandom);
      ex_ready  = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 59) == 0);
      cyc();
    end
    feed_ack = 1'b0; flush = 1'b0;

    // Asynchronous reset with work in flight.
    ex_ready = 1'b1;
    repeat (8) cyc();
    ex_ready = 1'b0;
    bundle(2'b10, 16'h0300, 16'h0301, 16'h0302);
    check("arst_pre_occ3", 32'(occupancy), 32'd3);
    #2;
    a_rst = 1'b0;
    #1;
    check("arst_ex_valid", 32'(ex_valid), 32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    check("arst_feed_req", 32'(feed_req), 32'd1);
    @(posedge clk); #1;
    a_rst = 1'b1;
    ex_ready = 1'b1;
    bundle(2'b01, 16'h0400, 16'h0401, 16'h0);

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 200) begin
      cyc();
      wait_cnt++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Consumer end of the decode unit's micro-op feed handshake.
- Accepts bundles of 1-3 uops (uop_0..uop_2, uop_count) from the decoder and buffers them in a circular FIFO.
- Issues one uop per cycle, in execution order, to the execute stage over a valid/ready link.
- Generates the sf_written pulse the decoder uses to clear its flag-busy condition, and supports a flush for branch/PC invalidation.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- PTR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock.
- a_rst  input  1  reset, asynchronous, active-low.
- flush  input  1  discard all queued uops and any bundle offered this cycle.
- feed_req  output  1  queue can accept a full 3-uop bundle.
- feed_ack  input  1  decoder presents a valid bundle this cycle.
- uop_0  input  16  final uop of the instruction (ALU/last step).
- uop_1  input  16  middle uop (address step).
- uop_2  input  16  first uop (address step).
- uop_count  input  2  number of uops minus one (00=1, 01=2, 10=3, 11=3).
- ex_valid  output  1  ex_uop is valid.
- ex_ready  input  1  execute stage takes ex_uop this cycle.
- ex_uop  output  16  uop at the FIFO head.
- ex_last  output  1  ex_uop is the last uop of its instruction.
- sf_written  output  1  one-cycle pulse: an issued uop writes flags.
- occupancy  output  PTR_W+1  entries currently held.

Behaviour:
- Reset (a_rst low, async): wr_ptr=0, rd_ptr=0, occupancy=0, ex_valid=0, sf_written=0, feed_req=1. FIFO contents are don't-care.
- Entry layout is 17 bits: {last, uop[15:0]}.
- Accept: the bundle is written on the rising edge when feed_req & feed_ack & ~flush.
- feed_req is combinational: (DEPTH - occupancy >= 3) & ~flush. It depends only on registered occupancy, never on feed_ack.
- Write order for n = uop_count+1 (count 11 treated as n=3):
  - n=3: uop_2, uop_1, uop_0 written to wr_ptr, wr_ptr+1, wr_ptr+2.
  - n=2: uop_1, uop_0.
  - n=1: uop_0.
  - The last flag is set only on the uop_0 entry.
  - wr_ptr advances by n, modulo DEPTH (wrap-around is natural pointer overflow).
- Issue (first-word-fall-through):
  - ex_uop and ex_last come from FIFO[rd_ptr].
  - ex_valid = (occupancy != 0) & ~flush.
  - Pop happens when ex_valid & ex_ready; rd_ptr increments modulo DEPTH.
- Latency: a bundle accepted at edge N can appear on ex_valid in the cycle after edge N. No same-cycle bypass into an empty queue.
- Simultaneous accept and pop in one cycle: occupancy_next = occupancy + n - 1. Full/empty is derived from occupancy, never from pointer equality.
- ex_ready while ex_valid=0 has no effect.
- sf_written: registered. It is 1 in the cycle following a pop whose uop[8] (write-flags bit) = 1, otherwise 0. No pulse for uops discarded by flush.
- Flush:
  - On the edge with flush=1: rd_ptr <= wr_ptr and occupancy <= 0.
  - An offered bundle is not written and no pop occurs; feed_req and ex_valid are 0 during the flush cycle.
  - A sf_written pulse scheduled by the previous cycle's pop still fires.
- Overflow is impossible by construction. A feed_ack while feed_req=0 is ignored (not written).
- Async reset mid-operation: all state returns to reset values immediately; the queue is empty on release.

Test Plan:
- Reset, then one bundle with uop_count=10, uop_2=16'h2222, uop_1=16'h1111, uop_0=16'h0100, ex_ready=1 -> ex_uop sequence 2222, 1111, 0100 on three consecutive cycles starting 1 cycle after accept. ex_last=1 only on 0100. sf_written=1 one cycle after 0100 issues.
- DEPTH=8, ex_ready=0: three 3-uop bundles offered back-to-back -> first two accepted (occupancy 3, 6). feed_req=0 at occupancy 6, so the third is ignored. Then ex_ready=1 for one pop -> occupancy 5, feed_req=1.
- Wrap-around: fill and drain repeatedly with 1/2/3-uop bundles for 40 bundles (pointer wraps multiple times) -> issued stream equals the scoreboard order exactly, with correct ex_last per instruction.
- Simultaneous accept and pop with occupancy=4, n=2 -> occupancy=5 next cycle; head uop unchanged except for the advance by one.
- Flush with occupancy=5 and a bundle offered in the same cycle -> occupancy=0 and ex_valid=0 next cycle, the offered bundle is never issued, and no sf_written for the discarded uops.
- a_rst asserted with occupancy=3 and ex_valid=1 -> ex_valid=0, occupancy=0, feed_req=1 immediately (asynchronously), before the next clock edge.
